// File: rtl/compare_tally_8_if.sv
// compare_tally_8_if: sample handshake and tally readout bus for compare_tally_8
interface compare_tally_8_if #(parameter int CNT_W = 8);
  logic             iStart;
  logic             iValid;
  logic [7:0]       iData_a;
  logic [7:0]       iData_b;
  logic [2:0]       iCmp;
  logic             oReady;
  logic [CNT_W-1:0] oGt_cnt;
  logic [CNT_W-1:0] oLt_cnt;
  logic [CNT_W-1:0] oEq_cnt;
  logic [7:0]       oMax;
  logic             oErr;
  logic             oDone;
  modport master (
    output iStart, iValid, iData_a, iData_b, iCmp,
    input  oReady, oGt_cnt, oLt_cnt, oEq_cnt, oMax, oErr, oDone
  );
  modport slave (
    input  iStart, iValid, iData_a, iData_b, iCmp,
    output oReady, oGt_cnt, oLt_cnt, oEq_cnt, oMax, oErr, oDone
  );
endinterface

// File: rtl/compare_tally_8.sv
// compare_tally_8: tallies comparator result codes over fixed batches, tracks max winner
// Optional COMPARE_TALLY_CHECK_EN re-checks legal codes against a local compare of the operands.
module compare_tally_8 #(
  parameter int CNT_W = 8,
  parameter int BATCH = 16
) (
  input  logic             iClk,
  input  logic             iRst_n,
  compare_tally_8_if.slave bus
);
  localparam int SW = $clog2(BATCH + 1);
  localparam logic [CNT_W-1:0] SAT = {CNT_W{1'b1}};
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [SW-1:0]    smp_q, smp_d;
  logic [CNT_W-1:0] gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic [7:0]       max_q, max_d, win;
  logic             err_q, err_d;
  logic             hs, clr, last, is_gt, is_lt, is_eq, ok;
  always_comb begin
    hs    = state_q == RUN && bus.iValid;
    clr   = state_q != RUN && bus.iStart;
    last  = hs && smp_q == SW'(BATCH - 1);
    is_gt = bus.iCmp == 3'b100;
    is_lt = bus.iCmp == 3'b010;
    is_eq = bus.iCmp == 3'b001;
`ifdef COMPARE_TALLY_CHECK_EN
    ok    = (is_gt && bus.iData_a > bus.iData_b) || (is_lt && bus.iData_a < bus.iData_b) ||
            (is_eq && bus.iData_a == bus.iData_b);
`else
    ok    = is_gt || is_lt || is_eq;
`endif
    win     = is_lt ? bus.iData_b : bus.iData_a;
    state_d = state_q == RUN ? (last ? DONE : RUN) : (bus.iStart ? RUN : state_q);
    smp_d   = clr ? '0 : hs ? smp_q + 1'b1 : smp_q;
    gt_d    = clr ? '0 : (hs && ok && is_gt && gt_q != SAT) ? gt_q + 1'b1 : gt_q;
    lt_d    = clr ? '0 : (hs && ok && is_lt && lt_q != SAT) ? lt_q + 1'b1 : lt_q;
    eq_d    = clr ? '0 : (hs && ok && is_eq && eq_q != SAT) ? eq_q + 1'b1 : eq_q;
    max_d   = clr ? '0 : (hs && ok && win > max_q) ? win : max_q;
    err_d   = clr ? 1'b0 : err_q | (hs && !ok);
  end
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      smp_q   <= '0;
      gt_q    <= '0;
      lt_q    <= '0;
      eq_q    <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end
  assign bus.oReady  = state_q == RUN;
  assign bus.oDone   = state_q == DONE;
  assign bus.oGt_cnt = gt_q;
  assign bus.oLt_cnt = lt_q;
  assign bus.oEq_cnt = eq_q;
  assign bus.oMax    = max_q;
  assign bus.oErr    = err_q;
endmodule
